laser_hit_detector: RTL and testbench

LASER_HIT_DETECTOR -- requirements
Module: laser_hit_detector

---
 rtl/stg_pkg.sv | 18 +
 rtl/frame_overlap_latch.sv | 35 +++
 rtl/laser_hit_detector.sv | 131 +++++++++++++
 tb/tb_laser_hit_detector.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// Shared game package: enemy state encoding, play-field size and combo threshold.
package stg_pkg;

    localparam int unsigned MAX_X = 384;
    localparam int unsigned MAX_Y = 448;
    localparam int unsigned COMBO_THRESHOLD = 7;

    typedef enum logic [1:0] {
        StAlive,
        StFlash,
        StDefeated
    } enemy_state_e;

    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/frame_overlap_latch.sv
// Detects the last pixel of the play field and latches laser/enemy coincidence within a frame.
module frame_overlap_latch
    import stg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       laser_on,
    input  logic       enemy_on,
    output logic       frame_end,
    output logic       overlap
);

    logic overlap_q;
    logic coincide;

    always_comb begin
        coincide  = laser_on & enemy_on;
        frame_end = (x == 10'(MAX_X - 1)) && (y == 10'(MAX_Y - 1));
        // Same-cycle coincidence counts, so a hit on the frame_end pixel is not lost.
        overlap   = overlap_q | coincide;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overlap_q <= 1'b0;
        end else if (frame_end) begin
            overlap_q <= 1'b0;
        end else if (coincide) begin
            overlap_q <= 1'b1;
        end
    end

endmodule

// File: rtl/laser_hit_detector.sv
// Per-frame laser hit detection, enemy HP and ALIVE/FLASH/DEFEATED state.
// Optional combo damage boost enabled with macro LASER_HIT_COMBO_EN.
module laser_hit_detector
    import stg_pkg::*;
#(
    parameter int unsigned HP_INIT      = 100,
    parameter int unsigned DAMAGE       = 1,
    parameter int unsigned FLASH_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       laser_on,
    input  logic       enemy_on,
    input  logic       revive,
    output logic [7:0] hp,
    output logic       hit,
    output logic       flash,
    output logic       defeated
);

    localparam logic [7:0] HpInit      = 8'(HP_INIT);
    localparam logic [7:0] DamageBase  = 8'(DAMAGE);
    localparam logic [3:0] FlashFrames = 4'(FLASH_FRAMES);

    enemy_state_e state_q;
    logic [3:0]   flash_cnt_q;
    logic [7:0]   hp_q;
    logic         hit_q;
    logic         flash_q;
    logic         defeated_q;
    logic [7:0]   damage;
    logic [7:0]   hp_after_hit;
    logic         frame_end;
    logic         overlap;

    frame_overlap_latch u_frame_overlap_latch (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .laser_on  (laser_on),
        .enemy_on  (enemy_on),
        .frame_end (frame_end),
        .overlap   (overlap)
    );

`ifdef LASER_HIT_COMBO_EN
    localparam int unsigned DamageDouble = 2 * DAMAGE;
    localparam logic [7:0]  DamageCombo  = (DamageDouble > 255) ? 8'd255 : 8'(DamageDouble);

    logic [2:0] combo_q;

    assign damage = (combo_q == 3'(COMBO_THRESHOLD)) ? DamageCombo : DamageBase;

    // Counts consecutive hit frames; FLASH frames in between neither add nor break a combo.
    always_ff @(posedge clk) begin
        if (reset) begin
            combo_q <= 3'd0;
        end else if (state_q == StDefeated) begin
            combo_q <= 3'd0;
        end else if (state_q == StAlive && frame_end) begin
            if (!overlap) begin
                combo_q <= 3'd0;
            end else if (combo_q != 3'(COMBO_THRESHOLD)) begin
                combo_q <= combo_q + 3'd1;
            end
        end
    end
`else
    assign damage = DamageBase;
`endif

    assign hp_after_hit = sat_sub8(hp_q, damage);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAlive;
            hp_q        <= HpInit;
            flash_cnt_q <= 4'd0;
            hit_q       <= 1'b0;
            flash_q     <= 1'b0;
            defeated_q  <= 1'b0;
        end else begin
            hit_q      <= 1'b0;
            flash_q    <= (state_q == StFlash);
            defeated_q <= (state_q == StDefeated);
            unique case (state_q)
                StAlive: begin
                    if (frame_end && overlap) begin
                        hp_q  <= hp_after_hit;
                        hit_q <= 1'b1;
                        if (hp_after_hit == 8'd0) begin
                            state_q <= StDefeated;
                        end else begin
                            state_q     <= StFlash;
                            flash_cnt_q <= FlashFrames;
                        end
                    end
                end
                StFlash: begin
                    if (frame_end) begin
                        flash_cnt_q <= flash_cnt_q - 4'd1;
                        if (flash_cnt_q == 4'd1) begin
                            state_q <= StAlive;
                        end
                    end
                end
                StDefeated: begin
                    // Revive wins over any same-cycle frame_end since DEFEATED ignores frames.
                    if (revive) begin
                        hp_q    <= HpInit;
                        state_q <= StAlive;
                    end else begin
                        hp_q <= 8'd0;
                    end
                end
                default: begin
                    state_q <= StAlive;
                end
            endcase
        end
    end

    assign hp       = hp_q;
    assign hit      = hit_q;
    assign flash    = flash_q;
    assign defeated = defeated_q;

endmodule

// File: tb/tb_laser_hit_detector.sv
// Randomized frame-level bench for laser_hit_detector against a per-frame reference model.
module tb_laser_hit_detector;

`ifdef LASER_HIT_COMBO_EN
    localparam bit ComboEn = 1'b1;
`else
    localparam bit ComboEn = 1'b0;
`endif
    localparam int Dmg = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       laser_on = 1'b0;
    logic       enemy_on = 1'b0;
    logic       revive = 1'b0;

    logic [7:0] hp_a, hp_b, hp_c;
    logic       hit_a, hit_b, hit_c;
    logic       flash_a, flash_b, flash_c;
    logic       def_a, def_b, def_c;

    logic [7:0] hp_v   [3];
    logic       hit_v  [3];
    logic       flash_v[3];
    logic       def_v  [3];

    always #5 clk = ~clk;

    laser_hit_detector #(.HP_INIT(100), .DAMAGE(1), .FLASH_FRAMES(4)) dut_a (
        .clk(clk), .reset(reset), .x(x), .y(y), .laser_on(laser_on), .enemy_on(enemy_on),
        .revive(revive), .hp(hp_a), .hit(hit_a), .flash(flash_a), .defeated(def_a)
    );
    laser_hit_detector #(.HP_INIT(3), .DAMAGE(1), .FLASH_FRAMES(1)) dut_b (
        .clk(clk), .reset(reset), .x(x), .y(y), .laser_on(laser_on), .enemy_on(enemy_on),
        .revive(revive), .hp(hp_b), .hit(hit_b), .flash(flash_b), .defeated(def_b)
    );
    laser_hit_detector #(.HP_INIT(100), .DAMAGE(1), .FLASH_FRAMES(1)) dut_c (
        .clk(clk), .reset(reset), .x(x), .y(y), .laser_on(laser_on), .enemy_on(enemy_on),
        .revive(revive), .hp(hp_c), .hit(hit_c), .flash(flash_c), .defeated(def_c)
    );

    always_comb begin
        hp_v[0] = hp_a;     hp_v[1] = hp_b;     hp_v[2] = hp_c;
        hit_v[0] = hit_a;   hit_v[1] = hit_b;   hit_v[2] = hit_c;
        flash_v[0] = flash_a; flash_v[1] = flash_b; flash_v[2] = flash_c;
        def_v[0] = def_a;   def_v[1] = def_b;   def_v[2] = def_c;
    end

    // Reference model: one record per enemy, advanced once per frame.
    typedef struct {
        int hp;
        int flash_left;
        bit dead;
        int combo;
        bit hit;
    } mdl_t;

    int   p_hp[3] = '{100, 3, 100};
    int   p_ff[3] = '{4, 1, 1};
    mdl_t m[3];
    bit   frame_ov;
    int   tests = 0;
    int   fails = 0;

    function automatic mdl_t frame_step(mdl_t mi, bit ov, bit rev, int hp_init, int ff);
        mdl_t mo;
        int   dmg;
        mo = mi;
        mo.hit = 1'b0;
        if (mo.dead) begin
            if (rev) begin
                mo.hp = hp_init;
                mo.dead = 1'b0;
            end
        end else if (mo.flash_left > 0) begin
            mo.flash_left--;
        end else if (ov) begin
            dmg = (ComboEn && mo.combo >= 7) ? ((2 * Dmg > 255) ? 255 : 2 * Dmg) : Dmg;
            mo.hp = (mo.hp > dmg) ? mo.hp - dmg : 0;
            mo.hit = 1'b1;
            if (mo.combo < 7) mo.combo++;
            if (mo.hp == 0) begin
                mo.dead = 1'b1;
                mo.combo = 0;
            end else begin
                mo.flash_left = ff;
            end
        end else begin
            mo.combo = 0;
        end
        return mo;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m[k].hp = p_hp[k];
            m[k].flash_left = 0;
            m[k].dead = 1'b0;
            m[k].combo = 0;
            m[k].hit = 1'b0;
        end
        frame_ov = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        x = 10'($urandom_range(0, 382));
        y = 10'($urandom_range(0, 1023));
        laser_on = 1'b1;
        enemy_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        laser_on = 1'b0;
        enemy_on = 1'b0;
        model_reset();
    endtask

    task automatic drive_pixel(input logic [9:0] px, input logic [9:0] py, input bit l,
                               input bit e);
        x = px;
        y = py;
        laser_on = l;
        enemy_on = e;
        frame_ov |= (l & e);
        @(posedge clk); #1;
    endtask

    // mode 0: no overlap, 1: first pixel overlaps, 2: random.
    task automatic random_pixels(input int n, input int mode);
        logic [9:0] px, py;
        bit l, e;
        for (int i = 0; i < n; i++) begin
            px = 10'($urandom_range(0, 382));
            py = 10'($urandom_range(0, 1023));
            l = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            if (mode == 0 && l) e = 1'b0;
            if (mode == 1 && i == 0) begin
                l = 1'b1;
                e = 1'b1;
            end
            drive_pixel(px, py, l, e);
        end
    endtask

    task automatic end_frame(input bit l, input bit e, input bit rev);
        x = 10'd383;
        y = 10'd447;
        laser_on = l;
        enemy_on = e;
        revive = rev;
        frame_ov |= (l & e);
        @(posedge clk); #1;
        revive = 1'b0;
        for (int k = 0; k < 3; k++) m[k] = frame_step(m[k], frame_ov, rev, p_hp[k], p_ff[k]);
        frame_ov = 1'b0;
    endtask

    task automatic idle_cycle();
        x = 10'd0;
        y = 10'd0;
        laser_on = 1'b0;
        enemy_on = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (hp_v[k] !== 8'(p_hp[k]) || hit_v[k] !== 1'b0 || flash_v[k] !== 1'b0 ||
                def_v[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset dut%0d: hp=%0d hit=%b flash=%b def=%b, want hp=%0d 0 0 0",
                         k, hp_v[k], hit_v[k], flash_v[k], def_v[k], p_hp[k]);
            end
        end
    endtask

    task automatic test_single_pixel();
        apply_reset();
        drive_pixel(10'd100, 10'd200, 1'b1, 1'b1);
        random_pixels(2, 0);
        end_frame(1'b0, 1'b0, 1'b0);
        tests++;
        if (hit_a !== 1'b1 || hp_a !== 8'd99) begin
            fails++;
            $display("FAIL single_pixel_hit: hit=%b hp=%0d, want hit=1 hp=99", hit_a, hp_a);
        end
        idle_cycle();
        tests++;
        if (hit_a !== 1'b0 || flash_a !== 1'b1) begin
            fails++;
            $display("FAIL single_pixel_pulse: hit=%b flash=%b, want hit=0 flash=1",
                     hit_a, flash_a);
        end
        for (int i = 0; i < 4; i++) begin
            random_pixels(2, 2);
            end_frame(1'b1, 1'b1, 1'b0);
            idle_cycle();
            tests++;
            if (flash_a !== (i < 3) || hp_a !== 8'd99 || hit_a !== 1'b0) begin
                fails++;
                $display("FAIL single_pixel_flash frame %0d: flash=%b hp=%0d, want flash=%b hp=99",
                         i, flash_a, hp_a, (i < 3));
            end
        end
    endtask

    task automatic test_frame_end_pixel();
        apply_reset();
        random_pixels(3, 0);
        end_frame(1'b1, 1'b1, 1'b0);
        tests++;
        if (hit_a !== 1'b1 || hp_a !== 8'd99) begin
            fails++;
            $display("FAIL frame_end_pixel: hit=%b hp=%0d, want hit=1 hp=99", hit_a, hp_a);
        end
    endtask

    task automatic test_defeat();
        int exp_hp[8] = '{2, 2, 1, 1, 0, 0, 0, 0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            random_pixels(1, 1);
            end_frame(1'b1, 1'b1, 1'b0);
            tests++;
            if (hp_b !== 8'(exp_hp[i]) || hit_b !== (i == 0 || i == 2 || i == 4)) begin
                fails++;
                $display("FAIL defeat_hp frame %0d: hp=%0d hit=%b, want hp=%0d hit=%b", i, hp_b,
                         hit_b, exp_hp[i], (i == 0 || i == 2 || i == 4));
            end
            idle_cycle();
            tests++;
            if (def_b !== (i >= 4)) begin
                fails++;
                $display("FAIL defeat_flag frame %0d: defeated=%b, want %b", i, def_b, (i >= 4));
            end
        end
    endtask

    task automatic test_revive();
        int n;
        apply_reset();
        n = 0;
        while (!m[0].dead && n < 700) begin
            random_pixels(1, 1);
            end_frame(1'b1, 1'b1, 1'b0);
            idle_cycle();
            n++;
        end
        tests++;
        if (def_a !== 1'b1 || hp_a !== 8'd0) begin
            fails++;
            $display("FAIL revive_reach_defeat after %0d frames: defeated=%b hp=%0d, want 1 0",
                     n, def_a, hp_a);
        end
        random_pixels(2, 1);
        end_frame(1'b1, 1'b1, 1'b1);
        tests++;
        if (hp_a !== 8'd100 || hit_a !== 1'b0) begin
            fails++;
            $display("FAIL revive_frame_end: hp=%0d hit=%b, want hp=100 hit=0", hp_a, hit_a);
        end
        idle_cycle();
        tests++;
        if (def_a !== 1'b0 || flash_a !== 1'b0) begin
            fails++;
            $display("FAIL revive_state: defeated=%b flash=%b, want 0 0", def_a, flash_a);
        end
    endtask

    task automatic test_reset_mid_flash();
        int n;
        apply_reset();
        n = 0;
        while (m[0].hp > 50 && n < 400) begin
            random_pixels(1, 1);
            end_frame(1'b1, 1'b1, 1'b0);
            idle_cycle();
            n++;
        end
        idle_cycle();
        tests++;
        if (hp_a !== 8'd50 || flash_a !== 1'b1) begin
            fails++;
            $display("FAIL mid_flash_setup: hp=%0d flash=%b, want hp=50 flash=1", hp_a, flash_a);
        end
        apply_reset();
        tests++;
        if (hp_a !== 8'd100 || flash_a !== 1'b0 || hit_a !== 1'b0) begin
            fails++;
            $display("FAIL mid_flash_reset: hp=%0d flash=%b hit=%b, want 100 0 0", hp_a,
                     flash_a, hit_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        drive_pixel(10'd50, 10'd60, 1'b1, 1'b1);
        apply_reset();
        random_pixels(2, 0);
        end_frame(1'b0, 1'b0, 1'b0);
        tests++;
        if (hit_a !== 1'b0 || hp_a !== 8'd100) begin
            fails++;
            $display("FAIL mid_frame_reset: hit=%b hp=%0d, want hit=0 hp=100", hit_a, hp_a);
        end
    endtask

    task automatic test_combo();
        int exp_c;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            random_pixels(1, 1);
            end_frame(1'b1, 1'b1, 1'b0);
            idle_cycle();
        end
        exp_c = ComboEn ? 91 : 92;
        tests++;
        if (hp_c !== 8'(exp_c) || hp_c !== 8'(m[2].hp)) begin
            fails++;
            $display("FAIL combo_eight_hits: hp=%0d, want %0d (model %0d)", hp_c, exp_c,
                     m[2].hp);
        end
    endtask

    task automatic test_random();
        bit l, e, rev;
        apply_reset();
        for (int f = 0; f < 250; f++) begin
            random_pixels(int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 15) == 0) begin
                revive = 1'b1;
                random_pixels(1, 0);
                revive = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (m[k].dead) begin
                        m[k].hp = p_hp[k];
                        m[k].dead = 1'b0;
                    end
                end
            end
            l = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            rev = ($urandom_range(0, 3) == 0);
            end_frame(l, e, rev);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (hit_v[k] !== m[k].hit || hp_v[k] !== 8'(m[k].hp)) begin
                    fails++;
                    $display("FAIL random_frame %0d dut%0d: hit=%b hp=%0d, want hit=%b hp=%0d",
                             f, k, hit_v[k], hp_v[k], m[k].hit, m[k].hp);
                end
            end
            idle_cycle();
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (hit_v[k] !== 1'b0 || flash_v[k] !== (!m[k].dead && m[k].flash_left > 0) ||
                    def_v[k] !== m[k].dead) begin
                    fails++;
                    $display("FAIL random_state %0d dut%0d: hit=%b flash=%b def=%b, want 0 %b %b",
                             f, k, hit_v[k], flash_v[k], def_v[k],
                             (!m[k].dead && m[k].flash_left > 0), m[k].dead);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_single_pixel();
        test_frame_end_pixel();
        test_defeat();
        test_revive();
        test_reset_mid_flash();
        test_reset_mid_frame();
        test_combo();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
